alu_vector_checker: RTL

Synthesizable, parametrised test-vector engine for the ALU/ALUdec pair. It streams packed vectors from a synchronous-read vector memory and drives opcode/funct/add_rshift_type/A/B into the DUT. After a programmable DUT latency it compares the DUT result against the expected value and keeps pass/fail counts plus a first-failure record. It is used on-chip/FPGA, and in sim as a self-checking wrapper around ALUdec+ALU, including pipelined ALU variants.

---
 rtl/alu_vector_checker.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_vector_checker.sv
// rtl/alu_vector_checker.sv - streams packed ALU vectors from memory, checks DUT results
//
// Purpose: reads {opcode, funct, add_rshift_type, A, B, expected} vectors from a
// synchronous-read vector memory, drives them into an ALUdec+ALU DUT, waits
// LATENCY cycles, then compares dut_out with expected. Keeps pass/fail counts
// and a record of the first mismatch.
//
// Ports:
//   Clock, Reset_n          rising-edge clock, synchronous active-low reset
//   start, num_vectors      run request (IDLE/DONE only) and vector count
//   vec_addr, vec_data      vector memory read port (data valid one cycle later)
//   opcode, funct, add_rshift_type, A, B   registered DUT stimulus
//   dut_out                 DUT result
//   busy, done, pass        run status
//   pass_count, fail_count  match / mismatch counters
//   fail_index, fail_got, fail_exp         first-mismatch record

module alu_vector_checker #(
  parameter int WIDTH        = 32,
  parameter int OPW          = 7,
  parameter int FUNCTW       = 3,
  parameter int DEPTH        = 32,
  parameter int ADDRW        = $clog2(DEPTH),
  parameter int LATENCY      = 0,
  parameter int STOP_ON_FAIL = 1,
  parameter int VW           = OPW + FUNCTW + 1 + 3 * WIDTH
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDRW:0]    num_vectors,
  output logic [ADDRW-1:0]  vec_addr,
  input  logic [VW-1:0]     vec_data,
  output logic [OPW-1:0]    opcode,
  output logic [FUNCTW-1:0] funct,
  output logic              add_rshift_type,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  input  logic [WIDTH-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDRW:0]    pass_count,
  output logic [ADDRW:0]    fail_count,
  output logic [ADDRW-1:0]  fail_index,
  output logic [WIDTH-1:0]  fail_got,
  output logic [WIDTH-1:0]  fail_exp
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Bit positions of the packed vector fields, LSB upward.
  localparam int B_LSB  = WIDTH;
  localparam int A_LSB  = 2 * WIDTH;
  localparam int T_BIT  = 3 * WIDTH;
  localparam int F_LSB  = 3 * WIDTH + 1;
  localparam int OP_LSB = 3 * WIDTH + 1 + FUNCTW;

  // Down-counter only needs to hold LATENCY-1.
  localparam int LATW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  localparam logic [ADDRW:0] DEPTH_V = (ADDRW + 1)'(DEPTH);

  logic [2:0]       state;
  logic [ADDRW-1:0] idx;
  logic [ADDRW:0]   num_reg;
  logic [WIDTH-1:0] expected;
  logic [LATW-1:0]  wait_cnt;

  logic [ADDRW:0]   num_clamped;
  logic             match;
  logic             last_vec;

  assign num_clamped = (num_vectors > DEPTH_V) ? DEPTH_V : num_vectors;
  assign match       = (dut_out == expected);
  assign last_vec    = ({1'b0, idx} == (num_reg - 1'b1));

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      num_reg         <= '0;
      expected        <= '0;
      wait_cnt        <= '0;
      vec_addr        <= '0;
      opcode          <= '0;
      funct           <= '0;
      add_rshift_type <= 1'b0;
      A               <= '0;
      B               <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      pass_count      <= '0;
      fail_count      <= '0;
      fail_index      <= '0;
      fail_got        <= '0;
      fail_exp        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Stimulus is left untouched so DONE keeps showing the last vector.
          if (start) begin
            num_reg    <= num_clamped;
            pass_count <= '0;
            fail_count <= '0;
            fail_index <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
            idx        <= '0;
            vec_addr   <= '0;
            if (num_clamped == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end

        S_FETCH: begin
          // vec_addr already holds idx; the memory registers it this cycle.
          state <= S_LOAD;
        end

        S_LOAD: begin
          opcode          <= vec_data[OP_LSB +: OPW];
          funct           <= vec_data[F_LSB +: FUNCTW];
          add_rshift_type <= vec_data[T_BIT];
          A               <= vec_data[A_LSB +: WIDTH];
          B               <= vec_data[B_LSB +: WIDTH];
          expected        <= vec_data[0 +: WIDTH];
          if (LATENCY == 0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= LATW'(LATENCY - 1);
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_CHECK: begin
          if (match) begin
            pass_count <= pass_count + 1'b1;
          end else begin
            fail_count <= fail_count + 1'b1;
            // Only the first mismatch of a run is recorded.
            if (fail_count == '0) begin
              fail_index <= idx;
              fail_got   <= dut_out;
              fail_exp   <= expected;
            end
          end
          if ((!match && (STOP_ON_FAIL != 0)) || last_vec) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= match && (fail_count == '0);
          end else begin
            idx      <= idx + 1'b1;
            vec_addr <= idx + 1'b1;
            state    <= S_FETCH;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
